store_buffer: RTL and testbench
===============================

# store_buffer

Store-path counterpart of the load extension logic in the core's memory stage. It aligns raw store data to its byte lane and generates byte strobes from the address offset and access size. Accepted stores are queued in a small in-order FIFO, which drains to data memory over a req/gnt handshake. It also flags misaligned stores and pending-store/load address conflicts, so the core can stall or trap.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- memaccess  in  memaccess_t  MEM_WRITE marks a store this cycle; MEM_READ marks a load
- addr  in  32  byte address of the current load or store
- wdata  in  32  raw store data (rs2), LSB-justified
- mask_mode  in  mask_mode_t  access size; MASK_BYTE_U/MASK_HALF_U are treated as MASK_BYTE/MASK_HALF
- store_stall  out  1  store presented while buffer full; core holds the store
- misaligned  out  1  current store is misaligned; not enqueued
- load_conflict  out  1  current load hits the word of a pending store
- empty  out  1  no pending stores (fence/drain indication)
- mem_req  out  1  head entry valid
- mem_addr  out  32  head word address, bits [1:0] = 0
- mem_wdata  out  32  head lane-aligned data
- mem_wstrb  out  4  head byte strobes
- mem_gnt  in  1  memory accepts head this cycle

## Operation
- Offset is addr[1:0]. Strobes: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111. Data is wdata << (8*off); bits shifted past bit 31 are discarded.
- Misaligned condition: half with off[0]=1, or word with off≠0. When memaccess==MEM_WRITE and the store is misaligned:
  - misaligned=1 (combinational);
  - no enqueue, store_stall=0.
- Enqueue condition: memaccess==MEM_WRITE, store aligned, count<DEPTH. The entry {addr[31:2], data, strb} is written at the tail on the clock edge.
- store_stall = MEM_WRITE && aligned && count==DEPTH. There is no same-cycle bypass: a grant in a full cycle frees its slot for the next cycle only.
- Dequeue: mem_req && mem_gnt on a clock edge pops the head. Order is strictly FIFO; entries are never merged or reordered.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): both occur and count is unchanged.
- Empty case: enqueue with count==0 and gnt=1 does not bypass; the entry appears at the head next cycle.
- load_conflict = MEM_READ && any valid entry has addr[31:2]==addr[31:2]. The check covers the head even if it is granted in the same cycle (conservative). The core stalls the load while this is asserted.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- mem_addr/mem_wdata/mem_wstrb are forced to 0 while empty.
- Inputs other than MEM_READ/MEM_WRITE (no access) leave the buffer unchanged and hold all flags at 0.

## Timing
- Reset (asynchronous, rst_n low): pointers and count cleared, all valid bits 0. Outputs: mem_req=0, empty=1, mem_addr/mem_wdata/mem_wstrb=0, store_stall=0. load_conflict=0 and misaligned=0 unless driven by current inputs.
- Reset mid-operation drops all pending stores immediately; nothing is written to memory after rst_n falls.
- Enqueue-to-mem_req latency: 1 cycle (mem_req is asserted in the cycle after the enqueue edge).
- Head fields are stable while mem_req=1 and mem_gnt=0.
- store_stall, misaligned and load_conflict are combinational from current inputs and registered state, with no registered delay.
- empty is registered-state-derived; it deasserts in the cycle after the first enqueue.

## Structure
- riscv_defines gains:
  - store_entry_t, a packed struct {logic [29:0] waddr; logic [31:0] data; logic [3:0] strb};
  - constant STORE_BUF_DEPTH = 4, used as the default instance parameter.
- One combinational sub-module, store_align_unit, maps (wdata, offset, mask_mode) to {data, strb, misaligned}. This is the write-side mirror of the load extension logic.
- Storage is an array of store_entry_t plus a valid vector. The conflict compare is a parallel DEPTH-way comparator on waddr.

## Test plan
- Byte store: sb at addr 0x0000_1003, wdata 0x0000_00AB, gnt=0. Next cycle: mem_req=1, mem_addr=0x0000_1000, mem_wdata=0xAB00_0000, mem_wstrb=4'b1000, empty=0.
- Misaligned: sh at 0x0000_2001. misaligned=1 the same cycle, empty remains 1, mem_req remains 0. Also sw at 0x0000_2002 gives misaligned=1.
- Full stall and ordering: 4 word stores to 0x10, 0x14, 0x18, 0x1C with gnt=0; the 5th store sees store_stall=1. One gnt pulse drains 0x10, store_stall drops the next cycle, and the 5th enqueues. Drain order is 0x14, 0x18, 0x1C, then the 5th.
- Load conflict: pending sh at 0x0000_1002. A load at 0x0000_1000 gives load_conflict=1; a load at 0x0000_1004 gives 0; a load issued in the grant cycle of that entry still gives 1.
- Concurrent push/pop: count=1, enqueue and gnt in the same cycle. Count stays 1, the new entry becomes head, and pointers wrap correctly over 2×DEPTH such cycles.
- Async reset: 3 entries pending, rst_n low mid-cycle. mem_req=0, empty=1 and mem_wstrb=0 before the next clock edge; no memory writes after release.

Source files
------------

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared memory-stage types and constants for the core
package riscv_defines;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memaccess_t;

    typedef enum logic [2:0] {
        MASK_BYTE   = 3'd0,
        MASK_HALF   = 3'd1,
        MASK_WORD   = 3'd2,
        MASK_BYTE_U = 3'd3,
        MASK_HALF_U = 3'd4
    } mask_mode_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  strb;
    } store_entry_t;

    localparam int STORE_BUF_DEPTH = 4;

endpackage

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - lane alignment, byte strobes and misalignment detect for stores
module store_align_unit
    import riscv_defines::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  mask_mode_t  mask_mode,
    output logic [31:0] data,
    output logic [3:0]  strb,
    output logic        misaligned
);

    always_comb begin
        data       = wdata << {offset, 3'b000};
        strb       = 4'b1111;
        misaligned = 1'b0;
        // Unsigned variants only matter on the load side; stores treat them as signed sizes.
        unique case (mask_mode)
            MASK_BYTE, MASK_BYTE_U: begin
                strb = 4'b0001 << offset;
            end
            MASK_HALF, MASK_HALF_U: begin
                strb       = 4'b0011 << offset;
                misaligned = offset[0];
            end
            default: begin
                strb       = 4'b1111;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO draining to data memory over req/gnt
module store_buffer
    import riscv_defines::*;
#(
    parameter int DEPTH = STORE_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  memaccess_t  memaccess,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  mask_mode_t  mask_mode,
    output logic        store_stall,
    output logic        misaligned,
    output logic        load_conflict,
    output logic        empty,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    store_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic [31:0]          align_data;
    logic [3:0]           align_strb;
    logic                 align_mis;
    logic                 is_write;
    logic                 is_read;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [DEPTH-1:0]     hit;
    store_entry_t         head;

    store_align_unit u_align (
        .wdata      (wdata),
        .offset     (addr[1:0]),
        .mask_mode  (mask_mode),
        .data       (align_data),
        .strb       (align_strb),
        .misaligned (align_mis)
    );

    assign is_write    = (memaccess == MEM_WRITE);
    assign is_read     = (memaccess == MEM_READ);
    assign full        = (count == FULL_CNT);
    assign misaligned  = is_write && align_mis;
    assign store_stall = is_write && !align_mis && full;
    assign push        = is_write && !align_mis && !full;
    assign pop         = mem_req && mem_gnt;

    // Conservative: a head granted this very cycle still counts as pending.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (entries[i].waddr == addr[31:2]);
        end
    end

    assign load_conflict = is_read && (|hit);

    assign empty     = (count == '0);
    assign mem_req   = valid[rd_ptr];
    assign head      = entries[rd_ptr];
    assign mem_addr  = mem_req ? {head.waddr, 2'b00} : 32'h0;
    assign mem_wdata = mem_req ? head.data : 32'h0;
    assign mem_wstrb = mem_req ? head.strb : 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; the valid vector alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{waddr: addr[31:2], data: align_data, strb: align_strb};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
    import riscv_defines::*;

    logic        clk;
    logic        rst_n;
    memaccess_t  memaccess;
    logic [31:0] addr;
    logic [31:0] wdata;
    mask_mode_t  mask_mode;
    logic        store_stall;
    logic        misaligned;
    logic        load_conflict;
    logic        empty;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;

    int vectors;
    int miscompares;

    store_buffer #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memaccess     (memaccess),
        .addr          (addr),
        .wdata         (wdata),
        .mask_mode     (mask_mode),
        .store_stall   (store_stall),
        .misaligned    (misaligned),
        .load_conflict (load_conflict),
        .empty         (empty),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_gnt       (mem_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input memaccess_t ma, input logic [31:0] a, input logic [31:0] d,
                         input mask_mode_t mm, input logic g);
        memaccess = ma;
        addr      = a;
        wdata     = d;
        mask_mode = mm;
        mem_gnt   = g;
        #1;
    endtask

    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(MEM_NONE, 32'h0, 32'h0, MASK_WORD, 1'b0);
        #2;
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        chk("reset_wstrb", 32'(mem_wstrb), 32'h0);
        chk("reset_stall", 32'(store_stall), 32'd0);
        #7 rst_n = 1'b1;
        tick();

        // Byte store into the top lane
        drive(MEM_WRITE, 32'h0000_1003, 32'h0000_00AB, MASK_BYTE, 1'b0);
        chk("sb_mis", 32'(misaligned), 32'd0);
        chk("sb_stall", 32'(store_stall), 32'd0);
        chk("sb_empty_same_cycle", 32'(empty), 32'd1);
        tick();
        drive(MEM_NONE, 32'h0, 32'h0, MASK_WORD, 1'b0);
        chk("sb_req", 32'(mem_req), 32'd1);
        chk("sb_addr", mem_addr, 32'h0000_1000);
        chk("sb_wdata", mem_wdata, 32'hAB00_0000);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
        chk("sb_empty", 32'(empty), 32'd0);
        tick();
        chk("sb_hold_addr", mem_addr, 32'h0000_1000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("sb_drained", 32'(empty), 32'd1);

        // Unsigned byte at offset 1, and a half whose upper source bits must be discarded
        drive(MEM_WRITE, 32'h0000_3001, 32'h0000_00CD, MASK_BYTE_U, 1'b0);
        tick();
        drive(MEM_WRITE, 32'h0000_3006, 32'hFFFF_1234, MASK_HALF_U, 1'b0);
        chk("bu_wdata", mem_wdata, 32'h0000_CD00);
        chk("bu_wstrb", 32'(mem_wstrb), 32'h2);
        tick();
        drive(MEM_NONE, 32'h0, 32'h0, MASK_WORD, 1'b1);
        tick();
        mem_gnt = 1'b0;
        chk("hu_addr", mem_addr, 32'h0000_3004);
        chk("hu_wdata", mem_wdata, 32'h1234_0000);
        chk("hu_wstrb", 32'(mem_wstrb), 32'hC);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("hu_drained", 32'(empty), 32'd1);

        // Misaligned stores are flagged and dropped
        drive(MEM_WRITE, 32'h0000_2001, 32'h0000_BEEF, MASK_HALF, 1'b0);
        chk("sh_mis", 32'(misaligned), 32'd1);
        chk("sh_mis_stall", 32'(store_stall), 32'd0);
        tick();
        drive(MEM_WRITE, 32'h0000_2002, 32'hDEAD_BEEF, MASK_WORD, 1'b0);
        chk("sw_mis", 32'(misaligned), 32'd1);
        chk("sh_mis_empty", 32'(empty), 32'd1);
        chk("sh_mis_req", 32'(mem_req), 32'd0);
        tick();
        drive(MEM_NONE, 32'h0000_2002, 32'h0, MASK_WORD, 1'b0);
        chk("none_mis", 32'(misaligned), 32'd0);
        chk("sw_mis_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, stall the fifth, release with one grant
        for (int i = 0; i < 4; i++) begin
            exp_addr[i] = 32'h10 + 32'(4 * i);
            exp_data[i] = 32'h1111_1111 * 32'(i + 1);
            drive(MEM_WRITE, exp_addr[i], exp_data[i], MASK_WORD, 1'b0);
            chk("fill_stall", 32'(store_stall), 32'd0);
            tick();
        end
        drive(MEM_WRITE, 32'h20, 32'h5555_5555, MASK_WORD, 1'b0);
        chk("full_stall", 32'(store_stall), 32'd1);
        chk("full_head", mem_addr, 32'h10);
        mem_gnt = 1'b1;
        #1;
        chk("full_gnt_stall", 32'(store_stall), 32'd1);
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("after_gnt_stall", 32'(store_stall), 32'd0);
        chk("after_gnt_head", mem_addr, 32'h14);
        tick();
        drive(MEM_NONE, 32'h0, 32'h0, MASK_WORD, 1'b0);
        exp_addr[0] = 32'h14; exp_data[0] = 32'h2222_2222;
        exp_addr[1] = 32'h18; exp_data[1] = 32'h3333_3333;
        exp_addr[2] = 32'h1C; exp_data[2] = 32'h4444_4444;
        exp_addr[3] = 32'h20; exp_data[3] = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            chk("drain_req", 32'(mem_req), 32'd1);
            chk("drain_addr", mem_addr, exp_addr[i]);
            chk("drain_data", mem_wdata, exp_data[i]);
            mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);

        // Load conflict against a pending halfword
        drive(MEM_WRITE, 32'h0000_1002, 32'h0000_1234, MASK_HALF, 1'b0);
        chk("write_no_conflict", 32'(load_conflict), 32'd0);
        tick();
        drive(MEM_READ, 32'h0000_1000, 32'h0, MASK_WORD, 1'b0);
        chk("ld_hit", 32'(load_conflict), 32'd1);
        drive(MEM_READ, 32'h0000_1004, 32'h0, MASK_WORD, 1'b0);
        chk("ld_miss", 32'(load_conflict), 32'd0);
        drive(MEM_NONE, 32'h0000_1000, 32'h0, MASK_WORD, 1'b0);
        chk("none_no_conflict", 32'(load_conflict), 32'd0);
        drive(MEM_READ, 32'h0000_1003, 32'h0, MASK_BYTE, 1'b1);
        chk("ld_hit_gnt_cycle", 32'(load_conflict), 32'd1);
        tick();
        drive(MEM_READ, 32'h0000_1000, 32'h0, MASK_WORD, 1'b0);
        chk("ld_after_pop", 32'(load_conflict), 32'd0);
        chk("ld_empty", 32'(empty), 32'd1);

        // Concurrent push/pop at count 1 across 2*DEPTH cycles
        drive(MEM_WRITE, 32'h100, 32'hA0A0_A0A0, MASK_WORD, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(MEM_WRITE, 32'h200 + 32'(4 * i), 32'(i), MASK_WORD, 1'b1);
            chk("pp_stall", 32'(store_stall), 32'd0);
            chk("pp_head", mem_addr, (i == 0) ? 32'h100 : 32'h200 + 32'(4 * (i - 1)));
            tick();
        end
        drive(MEM_NONE, 32'h0, 32'h0, MASK_WORD, 1'b0);
        chk("pp_last_head", mem_addr, 32'h21C);
        chk("pp_last_data", mem_wdata, 32'd7);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("pp_empty", 32'(empty), 32'd1);

        // Asynchronous reset with three entries pending
        for (int i = 0; i < 3; i++) begin
            drive(MEM_WRITE, 32'h40 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), MASK_WORD, 1'b0);
            tick();
        end
        drive(MEM_NONE, 32'h0, 32'h0, MASK_WORD, 1'b0);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_wstrb", 32'(mem_wstrb), 32'h0);
        mem_gnt = 1'b1;
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_req", 32'(mem_req), 32'd0);
        end
        drive(MEM_READ, 32'h40, 32'h0, MASK_WORD, 1'b0);
        chk("post_rst_conflict", 32'(load_conflict), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
